sdram_bist: RTL

Built-in self-test master that sits directly upstream of sdram_core_pc, on the sdram controller request/response channel, in place of the AXI-Lite bridge.
- On start, writes a deterministic pattern over a word range, reads it back, and compares.
- Reports pass/fail, error count and first failing address.
- Used for board bring-up and as a regression stimulus for the core and IO stages.

---
 rtl/sdram_bist_pkg.sv | 36 +++
 rtl/sdram_bist_lfsr.sv | 33 +++
 rtl/sdram_bist.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bist_pkg.sv
// Shared types and LFSR helpers for the SDRAM built-in self-test master.
package sdram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Right-shift Galois masks, bit k set for each x^(k+1) term below the leading one
  localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return TAPS_8;
      16:      return TAPS_16;
      32:      return TAPS_32;
      64:      return TAPS_64;
      default: return (64'd1 << (width - 1)) | 64'd1;
    endcase
  endfunction

  // Leading tap always set, so a nonzero state can never step to zero
  function automatic logic [63:0] lfsr_next(input logic [63:0] value, input int unsigned width);
    logic [63:0] nxt;
    nxt = value >> 1;
    if (value[0]) nxt = nxt ^ lfsr_taps(width);
    return nxt;
  endfunction

endpackage

// File: rtl/sdram_bist_lfsr.sv
// Galois LFSR with synchronous seed load and step enable.
module sdram_bist_lfsr
  import sdram_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter logic [31:0] SEED  = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  localparam logic [63:0]      SEED_REP = {SEED, SEED};
  localparam logic [WIDTH-1:0] SEED_W   = SEED_REP[WIDTH-1:0];

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)    value_d = SEED_W;
    else if (en) value_d = WIDTH'(lfsr_next(64'(value_q), WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= SEED_W;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/sdram_bist.sv
// SDRAM BIST master: writes a pattern over a word range, reads it back in order and compares.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [23:0]             word_count,
  input  logic                    mode,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_we,
  output logic [ADDR_WIDTH-1:0]   req_addr,
  output logic [DATA_WIDTH-1:0]   req_wdata,
  output logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic                    rsp_valid,
  input  logic [DATA_WIDTH-1:0]   rsp_rdata
);

  localparam int unsigned         OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]       OS_MAX    = OW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_e                  state_q, state_d;
  logic [23:0]             count_q, count_d, issued_q, issued_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d, rsp_addr_q, rsp_addr_d;
  logic [OW-1:0]           os_q, os_d;
  logic [15:0]             err_q, err_d;
  logic [ADDR_WIDTH-1:0]   first_q, first_d;
  logic                    pass_q, pass_d, done_q, done_d, busy_q, busy_d;
  logic                    req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic                    lfsr_load, wr_adv, cmp_adv;
  logic                    req_fire, rd_fire, rsp_fire;
  logic [DATA_WIDTH-1:0]   wr_value, cmp_value, expected;

  assign req_fire = req_valid_q && req_ready;
  assign rd_fire  = req_fire && !req_we_q;
  assign rsp_fire = rsp_valid && (os_q != '0) && (state_q == ST_READ || state_q == ST_DRAIN);
  assign expected = mode_q ? DATA_WIDTH'(rsp_addr_q) : cmp_value;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    issued_d    = issued_q;
    mode_d      = mode_q;
    base_d      = base_q;
    rsp_addr_d  = rsp_addr_q;
    err_d       = err_q;
    first_d     = first_q;
    pass_d      = pass_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    lfsr_load   = 1'b0;
    wr_adv      = 1'b0;
    cmp_adv     = 1'b0;

    case ({rd_fire, rsp_fire})
      2'b10:   os_d = os_q + OW'(1);
      2'b01:   os_d = os_q - OW'(1);
      default: os_d = os_q;
    endcase

    if (rsp_fire) begin
      cmp_adv    = 1'b1;
      rsp_addr_d = rsp_addr_q + ADDR_STEP;
      if (rsp_rdata != expected) begin
        if (err_q != '1) err_d = err_q + 16'd1;
        if (err_q == '0) first_d = rsp_addr_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          mode_d     = mode;
          rsp_addr_d = base_addr;
          issued_d   = '0;
          lfsr_load  = 1'b1;
          err_d      = '0;
          first_d    = '0;
          pass_d     = 1'b0;
          if (word_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_WRITE;
            req_valid_d = 1'b1;
            req_we_d    = 1'b1;
            req_addr_d  = base_addr;
          end
        end
      end
      ST_WRITE: begin
        if (req_fire) begin
          wr_adv   = 1'b1;
          issued_d = issued_q + 24'd1;
          if (issued_q + 24'd1 == count_q) begin
            state_d    = ST_READ;
            issued_d   = '0;
            req_we_d   = 1'b0;
            req_addr_d = base_q;
          end else begin
            req_addr_d = req_addr_q + ADDR_STEP;
          end
        end
      end
      ST_READ: begin
        if (req_fire) begin
          issued_d   = issued_q + 24'd1;
          req_addr_d = req_addr_q + ADDR_STEP;
        end
        // Valid for next cycle depends only on registered state, never on req_ready directly
        if (req_fire && (issued_q + 24'd1 == count_q)) begin
          state_d     = ST_DRAIN;
          req_valid_d = 1'b0;
        end else begin
          req_valid_d = (os_d < OS_MAX);
        end
      end
      ST_DRAIN: begin
        if (os_q == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
    if (state_d == ST_DONE) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      issued_q    <= '0;
      mode_q      <= 1'b0;
      base_q      <= '0;
      rsp_addr_q  <= '0;
      os_q        <= '0;
      err_q       <= '0;
      first_q     <= '0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      rsp_addr_q  <= rsp_addr_d;
      os_q        <= os_d;
      err_q       <= err_d;
      first_q     <= first_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
    end
  end

  sdram_bist_lfsr #(.WIDTH(DATA_WIDTH), .SEED(LFSR_SEED)) u_wr_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .en    (wr_adv),
    .value (wr_value)
  );

  sdram_bist_lfsr #(.WIDTH(DATA_WIDTH), .SEED(LFSR_SEED)) u_cmp_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .en    (cmp_adv),
    .value (cmp_value)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign req_valid      = req_valid_q;
  assign req_we         = req_we_q;
  assign req_addr       = req_addr_q;
  assign req_wdata      = req_we_q ? (mode_q ? DATA_WIDTH'(req_addr_q) : wr_value) : '0;
  assign req_wstrb      = '1;

endmodule
